param_sequencer: RTL

PARAM_SEQUENCER -- requirements
Module: param_sequencer

---
 rtl/param_sequencer_pkg.sv | 29 ++
 rtl/param_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/param_sequencer_pkg.sv
// Shared definitions for the parameter sequencer.
//   - seq_state_t     : sweep FSM states
//   - WORDS_PER_TRANS : BRAM words reserved per transducer channel
//   - WORDS_USED      : words actually read per channel (cycle, duty, phase)
//   - DEFAULT_CYCLE   : cycle value held by outputs and shadows after reset
//   - OFF_*           : word offsets inside a channel's BRAM block
//   - word_addr()     : channel/offset -> BRAM word address
package param_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_DRAIN  = 2'd2,
        S_COMMIT = 2'd3
    } seq_state_t;

    localparam int WORDS_PER_TRANS = 4;
    localparam int WORDS_USED      = 3;
    localparam int DEFAULT_CYCLE   = 5000;

    localparam logic [1:0] OFF_CYCLE = 2'd0;
    localparam logic [1:0] OFF_DUTY  = 2'd1;
    localparam logic [1:0] OFF_PHASE = 2'd2;

    function automatic logic [9:0] word_addr(input int unsigned chan, input logic [1:0] off);
        return 10'(chan * WORDS_PER_TRANS) + 10'(off);
    endfunction

endpackage

// File: rtl/param_sequencer.sv
// Parameter sequencer: on an enabled UPDATE strobe, sweeps the parameter BRAM
// (cycle, duty, phase for every channel), sanitises each word into a shadow
// register set and then commits all shadows to the outputs on a single edge.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   ENABLE, UPDATE  UPDATE starts a sweep only when ENABLE is high in IDLE
//   RAM_EN/RAM_ADDR BRAM read port (one address per cycle during READ)
//   RAM_DOUT        BRAM data, valid RAM_LATENCY cycles after its address
//   CYCLE/DUTY/PHASE committed per-channel values
//   BUSY            high in every state except IDLE
//   DONE            one-cycle pulse after the commit edge
//   OVERRUN         one-cycle pulse after an UPDATE dropped while BUSY
//   DBG_STATE       current FSM state (seq_state_t encoding)
//
// Handshake: UPDATE is a single-cycle strobe with no back-pressure; it is
// accepted only in IDLE with ENABLE high, otherwise it is either ignored
// (IDLE, ENABLE low) or dropped and flagged with OVERRUN (BUSY high).
module param_sequencer
    import param_seq_pkg::*;
#(
    parameter int WIDTH       = 13,
    parameter int TRANS_NUM   = 249,
    parameter int RAM_LATENCY = 2
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              ENABLE,
    input  logic                              UPDATE,
    output logic                              RAM_EN,
    output logic [9:0]                        RAM_ADDR,
    input  logic [15:0]                       RAM_DOUT,
    output logic [0:TRANS_NUM-1][WIDTH-1:0]   CYCLE,
    output logic [0:TRANS_NUM-1][WIDTH-1:0]   DUTY,
    output logic [0:TRANS_NUM-1][WIDTH-1:0]   PHASE,
    output logic                              BUSY,
    output logic                              DONE,
    output logic                              OVERRUN,
    output logic [1:0]                        DBG_STATE
);

    localparam int                CHAN_W    = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(TRANS_NUM - 1);
    localparam logic [WIDTH-1:0]  RST_CYCLE = WIDTH'(DEFAULT_CYCLE);

    seq_state_t state;

    // Address counter: channel and word offset currently presented on RAM_ADDR.
    logic [CHAN_W-1:0] chan_cnt;
    logic [1:0]        off_cnt;
    logic [CHAN_W-1:0] next_chan;
    logic [1:0]        next_off;
    logic              last_addr;

    // Valid-tag pipeline; stage RAM_LATENCY-1 lines up with RAM_DOUT.
    logic [RAM_LATENCY-1:0] tag_valid;
    logic [CHAN_W-1:0]      tag_chan [RAM_LATENCY];
    logic [1:0]             tag_off  [RAM_LATENCY];

    logic [0:TRANS_NUM-1][WIDTH-1:0] shadow_cycle;
    logic [0:TRANS_NUM-1][WIDTH-1:0] shadow_duty;
    logic [0:TRANS_NUM-1][WIDTH-1:0] shadow_phase;

    logic              cap_valid;
    logic [CHAN_W-1:0] cap_chan;
    logic [1:0]        cap_off;
    logic [WIDTH-1:0]  cap_word;
    logic [WIDTH-1:0]  cap_cyc_ref;
    logic [WIDTH-1:0]  duty_lim;
    logic [WIDTH-1:0]  phase_lim;
    logic              last_word;

    // Upper RAM_DOUT bits are deliberately ignored (values are WIDTH bits wide).
    logic unused_dout;
    assign unused_dout = ^RAM_DOUT;

    assign DBG_STATE = state;

    always_comb begin
        last_addr = (chan_cnt == LAST_CHAN) && (off_cnt == OFF_PHASE);
        next_off  = off_cnt + 2'd1;
        next_chan = chan_cnt;
        // Only WORDS_USED offsets are visited; the spare word is skipped.
        if (off_cnt == OFF_PHASE) begin
            next_off  = OFF_CYCLE;
            next_chan = chan_cnt + CHAN_W'(1);
        end
    end

    assign cap_valid   = tag_valid[RAM_LATENCY-1];
    assign cap_chan    = tag_chan[RAM_LATENCY-1];
    assign cap_off     = tag_off[RAM_LATENCY-1];
    assign cap_word    = RAM_DOUT[WIDTH-1:0];
    // Duty and phase of a channel always arrive after its cycle word, so the
    // shadow already holds the sanitised cycle used for clamping.
    assign cap_cyc_ref = shadow_cycle[cap_chan];
    assign duty_lim    = cap_cyc_ref >> 1;
    assign phase_lim   = cap_cyc_ref - WIDTH'(1);
    assign last_word   = cap_valid && (cap_chan == LAST_CHAN) && (cap_off == OFF_PHASE);

    // Sweep FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            chan_cnt <= '0;
            off_cnt  <= OFF_CYCLE;
            RAM_EN   <= 1'b0;
            RAM_ADDR <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            OVERRUN  <= 1'b0;
            CYCLE    <= {TRANS_NUM{RST_CYCLE}};
            DUTY     <= '0;
            PHASE    <= '0;
        end else begin
            DONE    <= 1'b0;
            // BUSY is still high on the commit edge, so an UPDATE there is dropped too.
            OVERRUN <= UPDATE && BUSY;
            case (state)
                S_IDLE: begin
                    if (UPDATE && ENABLE) begin
                        state    <= S_READ;
                        BUSY     <= 1'b1;
                        RAM_EN   <= 1'b1;
                        RAM_ADDR <= '0;
                        chan_cnt <= '0;
                        off_cnt  <= OFF_CYCLE;
                    end
                end
                S_READ: begin
                    if (last_addr) begin
                        RAM_EN <= 1'b0;
                        state  <= S_DRAIN;
                    end else begin
                        chan_cnt <= next_chan;
                        off_cnt  <= next_off;
                        RAM_ADDR <= word_addr(32'(next_chan), next_off);
                    end
                end
                S_DRAIN: begin
                    if (last_word) begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    CYCLE <= shadow_cycle;
                    DUTY  <= shadow_duty;
                    PHASE <= shadow_phase;
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag pipeline and shadow capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_valid    <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_chan[i] <= '0;
                tag_off[i]  <= '0;
            end
            shadow_cycle <= {TRANS_NUM{RST_CYCLE}};
            shadow_duty  <= '0;
            shadow_phase <= '0;
        end else begin
            tag_valid[0] <= RAM_EN;
            tag_chan[0]  <= chan_cnt;
            tag_off[0]   <= off_cnt;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_chan[i]  <= tag_chan[i-1];
                tag_off[i]   <= tag_off[i-1];
            end
            if (cap_valid) begin
                case (cap_off)
                    OFF_CYCLE: shadow_cycle[cap_chan] <= (cap_word == '0) ? WIDTH'(1) : cap_word;
                    OFF_DUTY:  shadow_duty[cap_chan]  <= (cap_word > duty_lim)  ? duty_lim  : cap_word;
                    OFF_PHASE: shadow_phase[cap_chan] <= (cap_word > phase_lim) ? phase_lim : cap_word;
                    default: ;
                endcase
            end
        end
    end

endmodule
